// File: rtl/avalon_edge_capture_pio.sv
// avalon_edge_capture_pio
// Avalon-MM slave PIO with a WIDTH-bit synchronised input port, per-bit edge
// capture with a maskable level interrupt, and a WIDTH-bit output register
// with atomic set/clear.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   chipselect, write       slave select and write strobe
//   address[2:0]            register index (0 DATA, 1 IRQMASK, 2 EDGECAP,
//                           3 OUTSET, 4 OUTCLR, 5..7 reserved)
//   writedata[31:0]         write data, bits [WIDTH-1:0] used
//   readdata[31:0]          registered read data, one cycle after address
//   in_port[WIDTH-1:0]      asynchronous external inputs
//   out_port[WIDTH-1:0]     output register contents
//   irq                     high while any unmasked captured edge is pending
module avalon_edge_capture_pio #(
    parameter int unsigned       WIDTH     = 10,
    parameter int unsigned       EDGE_TYPE = 0,
    parameter logic [WIDTH-1:0]  OUT_RESET = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PRIME_W = 2;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_IRQMASK = 3'd1;
    localparam logic [2:0] ADDR_EDGECAP = 3'd2;
    localparam logic [2:0] ADDR_OUTSET  = 3'd3;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd4;

    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(3);

    logic [WIDTH-1:0]   s1, s2, s3;
    logic [PRIME_W-1:0] prime_cnt;
    logic [WIDTH-1:0]   irq_mask;
    logic [WIDTH-1:0]   edge_cap;

    logic               wr_en;
    logic [WIDTH-1:0]   wd;
    logic [WIDTH-1:0]   edge_raw;
    logic [WIDTH-1:0]   edge_det;
    logic [WIDTH-1:0]   cap_clr;
    logic [WIDTH-1:0]   edge_cap_nxt;
    logic [WIDTH-1:0]   irq_mask_nxt;
    logic [WIDTH-1:0]   out_nxt;
    logic [DATA_W-1:0]  rd_nxt;

    // Upper writedata bits are intentionally ignored when WIDTH < 32.
    logic unused_wd;
    assign unused_wd = ^writedata;

    // Input synchroniser plus one extra stage for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Priming counter: suppresses the false edge seen while the
    // synchroniser fills from its reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
        end else if (prime_cnt != PRIME_DONE) begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
        end
    end

    // Bus decode, edge detect and next-state for all registers.
    always_comb begin
        wr_en        = chipselect & write;
        wd           = writedata[WIDTH-1:0];
        edge_raw     = s2 ^ s3;
        cap_clr      = '0;
        irq_mask_nxt = irq_mask;
        out_nxt      = out_port;
        rd_nxt       = '0;

        if (EDGE_TYPE == 0) begin
            edge_raw = s2 & ~s3;
        end else if (EDGE_TYPE == 1) begin
            edge_raw = ~s2 & s3;
        end

        edge_det = (prime_cnt == PRIME_DONE) ? edge_raw : '0;

        if (wr_en) begin
            case (address)
                ADDR_DATA:    out_nxt      = wd;
                ADDR_IRQMASK: irq_mask_nxt = wd;
                ADDR_EDGECAP: cap_clr      = wd;
                ADDR_OUTSET:  out_nxt      = out_port | wd;
                ADDR_OUTCLR:  out_nxt      = out_port & ~wd;
                default:      ;
            endcase
        end

        // A new edge in the same cycle as its clear keeps the bit set.
        edge_cap_nxt = (edge_cap & ~cap_clr) | edge_det;

        case (address)
            ADDR_DATA:    rd_nxt = DATA_W'(s2);
            ADDR_IRQMASK: rd_nxt = DATA_W'(irq_mask);
            ADDR_EDGECAP: rd_nxt = DATA_W'(edge_cap);
            default:      rd_nxt = '0;
        endcase
    end

    // Register state and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            edge_cap <= '0;
            out_port <= OUT_RESET;
            readdata <= '0;
        end else begin
            irq_mask <= irq_mask_nxt;
            edge_cap <= edge_cap_nxt;
            out_port <= out_nxt;
            readdata <= rd_nxt;
        end
    end

    // Level interrupt, combinational from registers only.
    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_avalon_edge_capture_pio.sv
// Directed bench for avalon_edge_capture_pio: one rising-edge instance
// (non-zero output reset value) and one any-edge instance sharing the bus.
module tb_avalon_edge_capture_pio;

    localparam int unsigned W = 10;
    localparam logic [W-1:0] OUT_RST0 = 10'h2A5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          chipselect;
    logic          write;
    logic [2:0]    address;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd0, rd2;
    logic [W-1:0]  out0, out2;
    logic          irq0, irq2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    avalon_edge_capture_pio #(.WIDTH(W), .EDGE_TYPE(0), .OUT_RESET(OUT_RST0)) dut0 (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .write(write), .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .out_port(out0), .irq(irq0)
    );

    avalon_edge_capture_pio #(.WIDTH(W), .EDGE_TYPE(2), .OUT_RESET(10'h000)) dut2 (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .write(write), .writedata(writedata), .readdata(rd2),
        .in_port(in_port), .out_port(out2), .irq(irq2)
    );

    typedef struct packed {
        logic          cs;
        logic          wr;
        logic [2:0]    addr;
        logic [31:0]   wd;
        logic [W-1:0]  exp_out;
        logic [31:0]   exp_rd;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance n clock edges and land 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus cycle; address is left driven so readdata keeps tracking it.
    task automatic bus(input logic cs, input logic wr, input logic [2:0] a, input logic [31:0] d);
        chipselect = cs;
        write      = wr;
        address    = a;
        writedata  = d;
        cyc(1);
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic do_reset(input logic [W-1:0] inp);
        in_port    = inp;
        chipselect = 1'b0;
        write      = 1'b0;
        address    = 3'd0;
        writedata  = '0;
        reset_n    = 1'b0;
        cyc(2);
        reset_n    = 1'b1;
    endtask

    initial begin
        //            cs    wr    addr  wd             exp_out  exp_rd
        tbl[0]  = '{1'b1, 1'b1, 3'd0, 32'h0000_00F0, 10'h0F0, 32'h0A5};
        tbl[1]  = '{1'b1, 1'b1, 3'd3, 32'h0000_0003, 10'h0F3, 32'h000};
        tbl[2]  = '{1'b1, 1'b1, 3'd4, 32'h0000_0030, 10'h0C3, 32'h000};
        tbl[3]  = '{1'b1, 1'b1, 3'd1, 32'hFFFF_F2AB, 10'h0C3, 32'h000};
        tbl[4]  = '{1'b0, 1'b0, 3'd1, 32'h0000_0000, 10'h0C3, 32'h2AB};
        tbl[5]  = '{1'b1, 1'b1, 3'd5, 32'h0000_03FF, 10'h0C3, 32'h000};
        tbl[6]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0000, 10'h0C3, 32'h0A5};
        tbl[7]  = '{1'b1, 1'b0, 3'd0, 32'h0000_03FF, 10'h0C3, 32'h0A5};
        tbl[8]  = '{1'b0, 1'b0, 3'd6, 32'h0000_0000, 10'h0C3, 32'h000};
        tbl[9]  = '{1'b1, 1'b1, 3'd4, 32'hFFFF_FFFF, 10'h000, 32'h000};
        tbl[10] = '{1'b1, 1'b1, 3'd3, 32'hFFFF_FFFF, 10'h3FF, 32'h000};
        tbl[11] = '{1'b0, 1'b0, 3'd2, 32'h0000_0000, 10'h3FF, 32'h000};
        tbl[12] = '{1'b0, 1'b0, 3'd7, 32'h0000_0000, 10'h3FF, 32'h000};

        // Reset with inputs held high; priming must hide the fill edge.
        in_port    = '1;
        chipselect = 1'b0;
        write      = 1'b0;
        address    = 3'd0;
        writedata  = '0;
        reset_n    = 1'b0;
        cyc(2);
        check("rst_readdata", rd0, 32'h0);
        check("rst_out0", 32'(out0), 32'(OUT_RST0));
        check("rst_out2", 32'(out2), 32'h0);
        check("rst_irq0", 32'(irq0), 32'h0);
        reset_n = 1'b1;
        cyc(2);
        check("data_lat_edge2", rd0, 32'h0);
        cyc(1);
        check("data_lat_edge3", rd0, 32'h3FF);
        cyc(3);
        bus(1'b0, 1'b0, 3'd2, 32'h0);
        check("prime_edgecap0", rd0, 32'h0);
        check("prime_edgecap2", rd2, 32'h0);
        check("prime_irq0", 32'(irq0), 32'h0);
        check("prime_irq2", 32'(irq2), 32'h0);

        // Falling edges: ignored by rising instance, captured by any-edge.
        in_port = 10'h0A5;
        cyc(4);
        bus(1'b0, 1'b0, 3'd2, 32'h0);
        check("fall_edgecap0", rd0, 32'h0);
        check("fall_edgecap2", rd2, 32'h35A);

        // Register map and output register vectors.
        for (int i = 0; i < 13; i++) begin
            bus(tbl[i].cs, tbl[i].wr, tbl[i].addr, tbl[i].wd);
            check($sformatf("vec%0d_out", i), 32'(out0), 32'(tbl[i].exp_out));
            check($sformatf("vec%0d_rd", i), rd0, tbl[i].exp_rd);
        end

        // Rising edge on bit0 with interrupt enabled, then clear.
        do_reset('0);
        cyc(5);
        bus(1'b1, 1'b1, 3'd1, 32'h001);
        in_port = 10'h001;
        cyc(2);
        check("irq_before_n2", 32'(irq0), 32'h0);
        cyc(1);
        check("irq_at_n2", 32'(irq0), 32'h1);
        bus(1'b0, 1'b0, 3'd2, 32'h0);
        check("cap_bit0", rd0, 32'h001);
        bus(1'b1, 1'b1, 3'd2, 32'h001);
        check("irq_after_clr", 32'(irq0), 32'h0);
        bus(1'b0, 1'b0, 3'd2, 32'h0);
        check("cap_after_clr", rd0, 32'h0);

        // Set beats clear on bit3; idle bit5 clears normally.
        in_port = 10'h021;
        cyc(4);
        bus(1'b0, 1'b0, 3'd2, 32'h0);
        check("cap_bit5", rd0, 32'h020);
        in_port = 10'h029;
        cyc(2);
        bus(1'b1, 1'b1, 3'd2, 32'h028);
        bus(1'b0, 1'b0, 3'd2, 32'h0);
        check("set_wins_clr", rd0, 32'h008);
        check("masked_irq", 32'(irq0), 32'h0);

        // Any-edge toggle on bit9 with mask 0, then unmask.
        do_reset(10'h200);
        cyc(5);
        in_port = 10'h000;
        cyc(2);
        in_port = 10'h200;
        cyc(4);
        bus(1'b0, 1'b0, 3'd2, 32'h0);
        check("any_cap2", rd2, 32'h200);
        check("rise_cap0", rd0, 32'h200);
        check("any_irq_masked", 32'(irq2), 32'h0);
        bus(1'b1, 1'b1, 3'd1, 32'h200);
        check("any_irq_unmasked", 32'(irq2), 32'h1);

        // Asynchronous reset in the middle of a clock period.
        do_reset('0);
        cyc(4);
        in_port = 10'h3FF;
        cyc(4);
        bus(1'b1, 1'b1, 3'd0, 32'h155);
        check("pre_rst_out", 32'(out0), 32'h155);
        bus(1'b1, 1'b1, 3'd1, 32'h3FF);
        bus(1'b0, 1'b0, 3'd2, 32'h0);
        check("pre_rst_cap", rd0, 32'h3FF);
        check("pre_rst_irq", 32'(irq0), 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rd", rd0, 32'h0);
        check("async_out0", 32'(out0), 32'(OUT_RST0));
        check("async_irq0", 32'(irq0), 32'h0);
        check("async_out2", 32'(out2), 32'h0);
        cyc(2);
        reset_n = 1'b1;
        cyc(6);
        bus(1'b0, 1'b0, 3'd2, 32'h0);
        check("reprime_cap", rd0, 32'h0);
        check("reprime_irq", 32'(irq0), 32'h0);
        bus(1'b0, 1'b0, 3'd1, 32'h0);
        check("reprime_mask", rd0, 32'h0);
        bus(1'b0, 1'b0, 3'd0, 32'h0);
        check("reprime_data", rd0, 32'h3FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/avalon_edge_capture_pio.md
# avalon_edge_capture_pio

Parametrised Avalon-MM slave PIO for the Nios II system: a WIDTH-bit synchronised input port with per-bit edge capture and a maskable interrupt, plus a WIDTH-bit output register with atomic set/clear. It replaces the fixed 10-bit input-only PIOs. The SRAM and other lab peripherals can then signal events to the CPU by interrupt instead of by polling.

## Interface
- WIDTH, 10, port width in bits, 1..32
- EDGE_TYPE, 0, capture condition: 0 rising, 1 falling, 2 any edge
- OUT_RESET, 0, reset value of the output register (WIDTH bits)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- chipselect  in  1  slave select, qualifies write
- address  in  3  register index
- write  in  1  write strobe, active-high, valid with chipselect
- writedata  in  32  write data, bits [WIDTH-1:0] used
- readdata  out  32  registered read data
- in_port  in  WIDTH  asynchronous external inputs
- out_port  out  WIDTH  output register contents
- irq  out  1  level interrupt, high while any unmasked captured edge is pending

## Operation
- Register map:
  - 0 DATA: read returns synchronised input; write loads the output register.
  - 1 IRQMASK: read/write, 1 = bit enabled.
  - 2 EDGECAP: read returns captured edges; write-1-to-clear per bit.
  - 3 OUTSET: write only, out |= wd.
  - 4 OUTCLR: write only, out &= ~wd.
  - 5..7: read 0, writes ignored. OUTSET and OUTCLR read 0.
- A write takes effect only when chipselect & write.
- Read bits [31:WIDTH] are always 0.
- Synchroniser: s1 <= in_port, s2 <= s1, s3 <= s2, every clk.
- Edge detect:
  - rising = s2 & ~s3
  - falling = ~s2 & s3
  - any = s2 ^ s3
- Priming: a 2-bit counter runs from 0 after reset and saturates at 3. Edge detect is gated off until the count is 3. Inputs held high through reset therefore produce no spurious capture.
- EDGECAP bit set: detected edge (when primed).
- EDGECAP bit clear: write 1 to address 2.
- Same-cycle detect and clear on one bit: the set wins and the bit stays 1.
- irq = |(EDGECAP & IRQMASK). It is combinational from registers only.
- readdata <= mux(address) every clk, independent of read/chipselect.

## Timing
- Reset values:
  - readdata = 0
  - out_port = OUT_RESET
  - IRQMASK = 0
  - EDGECAP = 0
  - s1/s2/s3 = 0
  - prime counter = 0
  - irq = 0
- Reset is asynchronous at any point, including mid-capture. All state returns to the reset values, and priming restarts on release.
- Read latency is 1 cycle: readdata shows the register addressed at edge N after edge N+1.
- Input path, for an in_port change settling before edge N:
  - s2 changes at N+1.
  - DATA readdata reflects it at N+2.
  - EDGECAP bit sets at N+2.
  - irq rises after N+2 if the bit is unmasked.
- Writes take effect at the edge where they are sampled. out_port and IRQMASK update at that edge. irq follows combinationally after it.
- Same-cycle write to address 0 and read of address 0: readdata returns the input, not the output register.
- Pulses shorter than one clk period may be missed. Bench stimulus must be no narrower than 2 periods.

## Test plan
- Reset with in_port=all ones, WIDTH=10 -> readdata=0, out_port=OUT_RESET. After 3 cycles DATA reads 0x3FF, EDGECAP reads 0, irq=0.
- EDGE_TYPE=0, IRQMASK=0x001, in_port bit0 0->1 before edge N -> EDGECAP=0x001 at N+2 and irq=1. Write 0x001 to addr 2 -> irq=0 on the next cycle.
- Same cycle: new rising edge on bit3 detected and write-clear of bit3 -> EDGECAP bit3 stays 1. Clear of an idle bit5 in that cycle -> 0.
- Write 0x0F0 to addr 0, 0x003 to addr 3, 0x030 to addr 4 -> out_port = 0x0F0, 0x0F3, 0x0C3 respectively, each on the write edge.
- EDGE_TYPE=2, 1->0->1 toggle on bit9 with IRQMASK=0 -> EDGECAP=0x200 and irq=0. Then write IRQMASK=0x200 -> irq=1.
- Assert reset_n low mid-capture with EDGECAP=0x3FF and out_port=0x155 -> all outputs return to reset values immediately, without waiting for clk.
